cp_motion: RTL and testbench
============================

CP_MOTION -- requirements
Module: cp_motion

Interface
REQ-001 SHALL provide parameter WIN_SCORE, default 11: points that end a game (1..15).
REQ-002 SHALL provide parameter SERVE_FRAMES, default 24: clk_24 rising edges waited before each serve (1..255).
REQ-003 SHALL have port clk_1  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous reset, active-high (1 = reset).
REQ-005 SHALL have port clk_24  input  1  frame tick level from the frame divider, asynchronous to clk_1.
REQ-006 SHALL have port start  input  1  level; starts a game from IDLE or OVER.
REQ-007 SHALL have port collide  input  1  datapath: paddle hit on the current step.
REQ-008 SHALL have port edg  input  2  datapath boundary code: 00 none, 01 left goal, 10 right goal, 11 top/bottom wall.
REQ-009 SHALL have port flag  input  1  datapath collision-processing done strobe.
REQ-010 SHALL have outputs Initial_ball, Activate_cntr, Compute_alter, Compute_collide, Value_select  output  1 each  dp_motion control lines.
REQ-011 SHALL have outputs score_l, score_r  output  4 each; rally  output  8; game_over  output  1.

Function
REQ-012 SHALL pass clk_24 through a 2-FF synchronizer; tick = one-cycle pulse on the synchronized rising edge (3 clk_1 latency).
REQ-013 SHALL implement states IDLE, SERVE, INIT, UPDATE, ALTER, COLLIDE, CHECK, OVER.
REQ-014 IDLE: all controls 0; start=1 -> SERVE; scores and rally cleared on that transition.
REQ-015 SERVE: Activate_cntr=1; 8-bit counter counts ticks; count reaching SERVE_FRAMES -> INIT, counter cleared.
REQ-016 INIT: Initial_ball=1 for exactly one cycle; Value_select cleared to 0; -> UPDATE.
REQ-017 UPDATE: all strobes 0; tick -> ALTER; no tick -> stay.
REQ-018 ALTER: Compute_alter=1 for exactly one cycle; -> COLLIDE.
REQ-019 COLLIDE: Compute_collide=1 held; flag=1 -> CHECK; 4 cycles without flag -> CHECK anyway (timeout).
REQ-020 Value_select SHALL be a register: 0 from INIT until the first COLLIDE entry, then 1 until next INIT or reset.
REQ-021 CHECK (one cycle), priority order: edg=01 -> score_r+1; edg=10 -> score_l+1; else collide=1 -> rally+1 saturating at 255; -> UPDATE.
REQ-022 After a point: updated score = WIN_SCORE -> OVER; else rally cleared, -> SERVE.
REQ-023 edg=11 or 00 with collide=0 SHALL change no counter and return to UPDATE.
REQ-024 OVER: game_over=1, scores held; start=1 -> SERVE with scores and rally cleared, game_over 0.
REQ-025 Exactly one of Initial_ball, Compute_alter, Compute_collide, Activate_cntr SHALL be high in any cycle, or none.
REQ-026 A tick arriving outside UPDATE/SERVE SHALL be dropped, not queued.
REQ-027 All outputs SHALL be registered (state-decoded into flops, no combinational path input->output).

Reset
REQ-028 rst_n=1 at any clock edge SHALL force IDLE, all control outputs 0, Value_select 0, scores 0, rally 0, game_over 0, serve counter 0, synchronizer flops 0.
REQ-029 Reset mid-COLLIDE or mid-SERVE SHALL abort the operation with no score change; first cycle after release is IDLE.

Verification
REQ-030 Reset 2 cycles, start=1, SERVE_FRAMES=2, toggle clk_24 twice -> Activate_cntr=1 throughout SERVE, then Initial_ball single pulse, Value_select=0.
REQ-031 In UPDATE, clk_24 rise -> Compute_alter pulse 4 cycles after the edge, next cycle Compute_collide=1; flag=1 -> CHECK; Value_select=1 from that COLLIDE on.
REQ-032 CHECK with edg=01 -> score_r 0->1, rally 0, return to SERVE; with edg=10 and collide=1 -> score_l+1 only (goal wins priority).
REQ-033 Three collide=1 cycles with edg=00 -> rally=3, scores unchanged; flag never asserted -> CHECK after 4 cycles of Compute_collide.
REQ-034 WIN_SCORE=2, two left-goal points -> score_r=2, game_over=1, FSM held in OVER; start=1 -> scores 0, SERVE.
REQ-035 Assert rst_n during COLLIDE -> next cycle all outputs 0, IDLE; controls never overlap across the whole run (assertion check).

Source files
------------

// File: rtl/cp_motion.sv
// Game-control FSM for the motion datapath: serve delay, ball init, per-frame step,
// collision handshake and scoring. Frame ticks from clk_24 are resynchronised to clk_1.
module cp_motion #(
  parameter int WIN_SCORE    = 11,
  parameter int SERVE_FRAMES = 24
) (
  input  logic       clk_1,
  input  logic       rst_n,
  input  logic       clk_24,
  input  logic       start,
  input  logic       collide,
  input  logic [1:0] edg,
  input  logic       flag,
  output logic       Initial_ball,
  output logic       Activate_cntr,
  output logic       Compute_alter,
  output logic       Compute_collide,
  output logic       Value_select,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [7:0] rally,
  output logic       game_over
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE   = 3'd1,
    INIT    = 3'd2,
    UPDATE  = 3'd3,
    ALTER   = 3'd4,
    COLLIDE = 3'd5,
    CHECK   = 3'd6,
    OVER    = 3'd7
  } state_t;

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [1:0] EDG_LEFT   = 2'b01;
  localparam logic [1:0] EDG_RIGHT  = 2'b10;

  state_t     state_r;
  logic       sync1_r;
  logic       sync2_r;
  logic       sync3_r;
  logic       tick_r;
  logic [7:0] serve_cnt_r;
  logic [1:0] coll_cnt_r;
  logic [3:0] score_l_nxt_s;
  logic [3:0] score_r_nxt_s;

  assign score_l_nxt_s = score_l + 4'd1;
  assign score_r_nxt_s = score_r + 4'd1;

  // Frame tick: two-flop synchronizer followed by a registered rising-edge detect.
  always_ff @(posedge clk_1) begin
    if (rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
      tick_r  <= 1'b0;
    end else begin
      sync1_r <= clk_24;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
      tick_r  <= sync2_r & ~sync3_r;
    end
  end

  // Control FSM; every output is loaded from the state being entered, so all are flops.
  always_ff @(posedge clk_1) begin
    if (rst_n) begin
      state_r         <= IDLE;
      Initial_ball    <= 1'b0;
      Activate_cntr   <= 1'b0;
      Compute_alter   <= 1'b0;
      Compute_collide <= 1'b0;
      Value_select    <= 1'b0;
      score_l         <= 4'd0;
      score_r         <= 4'd0;
      rally           <= 8'd0;
      game_over       <= 1'b0;
      serve_cnt_r     <= 8'd0;
      coll_cnt_r      <= 2'd0;
    end else begin
      Initial_ball    <= 1'b0;
      Activate_cntr   <= 1'b0;
      Compute_alter   <= 1'b0;
      Compute_collide <= 1'b0;
      case (state_r)
        IDLE, OVER: begin
          if (start) begin
            state_r       <= SERVE;
            Activate_cntr <= 1'b1;
            score_l       <= 4'd0;
            score_r       <= 4'd0;
            rally         <= 8'd0;
            game_over     <= 1'b0;
            serve_cnt_r   <= 8'd0;
          end else begin
            state_r <= state_r;
          end
        end
        SERVE: begin
          Activate_cntr <= 1'b1;
          if (tick_r) begin
            if (serve_cnt_r == SERVE_LAST) begin
              state_r       <= INIT;
              serve_cnt_r   <= 8'd0;
              Activate_cntr <= 1'b0;
              Initial_ball  <= 1'b1;
              Value_select  <= 1'b0;
            end else begin
              serve_cnt_r <= serve_cnt_r + 8'd1;
            end
          end else begin
            serve_cnt_r <= serve_cnt_r;
          end
        end
        INIT: begin
          state_r <= UPDATE;
        end
        UPDATE: begin
          if (tick_r) begin
            state_r       <= ALTER;
            Compute_alter <= 1'b1;
          end else begin
            state_r <= UPDATE;
          end
        end
        ALTER: begin
          state_r         <= COLLIDE;
          Compute_collide <= 1'b1;
          Value_select    <= 1'b1;
          coll_cnt_r      <= 2'd0;
        end
        COLLIDE: begin
          // Fourth cycle without the done strobe gives up and scores anyway.
          if (flag || (coll_cnt_r == 2'd3)) begin
            state_r    <= CHECK;
            coll_cnt_r <= 2'd0;
          end else begin
            Compute_collide <= 1'b1;
            coll_cnt_r      <= coll_cnt_r + 2'd1;
          end
        end
        CHECK: begin
          if (edg == EDG_LEFT) begin
            score_r <= score_r_nxt_s;
            if (score_r_nxt_s == WIN) begin
              state_r   <= OVER;
              game_over <= 1'b1;
            end else begin
              state_r       <= SERVE;
              Activate_cntr <= 1'b1;
              rally         <= 8'd0;
            end
          end else if (edg == EDG_RIGHT) begin
            score_l <= score_l_nxt_s;
            if (score_l_nxt_s == WIN) begin
              state_r   <= OVER;
              game_over <= 1'b1;
            end else begin
              state_r       <= SERVE;
              Activate_cntr <= 1'b1;
              rally         <= 8'd0;
            end
          end else begin
            state_r <= UPDATE;
            if (collide && (rally != 8'hFF)) begin
              rally <= rally + 8'd1;
            end else begin
              rally <= rally;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cp_motion.sv
// Self-checking bench for cp_motion: directed table, multi-cycle corner sequences and
// randomized rallies scored against a point-level model of the game rules.
module tb_cp_motion;

  localparam int WIN    = 2;
  localparam int FRAMES = 2;

  logic       clk_1 = 1'b0;
  logic       rst_n;
  logic       clk_24;
  logic       start;
  logic       collide;
  logic [1:0] edg;
  logic       flag;
  logic       Initial_ball;
  logic       Activate_cntr;
  logic       Compute_alter;
  logic       Compute_collide;
  logic       Value_select;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [7:0] rally;
  logic       game_over;
  logic [21:0] outs_s;

  int passed = 0;
  int total = 0;
  int overlap_cnt = 0;
  int m_l, m_r, m_rally;
  bit m_over, m_serve;

  cp_motion #(.WIN_SCORE(WIN), .SERVE_FRAMES(FRAMES)) dut (
    .clk_1(clk_1), .rst_n(rst_n), .clk_24(clk_24), .start(start),
    .collide(collide), .edg(edg), .flag(flag),
    .Initial_ball(Initial_ball), .Activate_cntr(Activate_cntr),
    .Compute_alter(Compute_alter), .Compute_collide(Compute_collide),
    .Value_select(Value_select), .score_l(score_l), .score_r(score_r),
    .rally(rally), .game_over(game_over)
  );

  always #5 clk_1 = ~clk_1;

  assign outs_s = {Initial_ball, Activate_cntr, Compute_alter, Compute_collide,
                   Value_select, game_over, score_l, score_r, rally};

  always @(negedge clk_1) begin
    if ($countones({Initial_ball, Activate_cntr, Compute_alter, Compute_collide}) > 1)
      overlap_cnt <= overlap_cnt + 1;
  end

  typedef struct {
    logic [1:0] edg;
    logic       col;
    int         d;
    int         sl;
    int         sr;
    int         rl;
    bit         serve;
    bit         over;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Point-level rules: goals score, otherwise a paddle hit extends the rally.
  task automatic model_check(input logic [1:0] e, input logic c);
    bit point;
    point = 1'b0;
    m_serve = 1'b0;
    if (e == 2'b01) begin m_r = m_r + 1; point = 1'b1; end
    else if (e == 2'b10) begin m_l = m_l + 1; point = 1'b1; end
    else if (c) m_rally = (m_rally >= 255) ? 255 : m_rally + 1;
    if (point) begin
      if (m_l == WIN || m_r == WIN) m_over = 1'b1;
      else begin m_rally = 0; m_serve = 1'b1; end
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, " score_l"}, score_l, m_l);
    chk({tag, " score_r"}, score_r, m_r);
    chk({tag, " rally"}, rally, m_rally);
    chk({tag, " game_over"}, game_over, m_over);
    chk({tag, " serve"}, Activate_cntr, m_serve);
  endtask

  // One frame step from UPDATE through CHECK; returns at the cycle after CHECK.
  task automatic do_step(input logic [1:0] e, input logic c, input int d, input bit tick_late);
    int lat, cc;
    bit seen;
    clk_24 = 1'b0;
    repeat (3) @(negedge clk_1);
    clk_24 = 1'b1;
    lat = 0; seen = 1'b0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge clk_1);
      if (Compute_alter) begin seen = 1'b1; lat = i; end
    end
    chk("alter_latency", lat, 4);
    clk_24 = 1'b0;
    edg = e; collide = c;
    @(negedge clk_1);
    chk("alter_then_collide", {Compute_alter, Compute_collide, Value_select}, 3'b011);
    if (tick_late) clk_24 = 1'b1;
    cc = 1;
    flag = (d == 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_1);
      if (!Compute_collide) break;
      cc++;
      flag = (cc == d + 1);
    end
    flag = 1'b0;
    chk("collide_cycles", cc, (d < 4) ? d + 1 : 4);
    chk("check_quiet", {Initial_ball, Activate_cntr, Compute_alter, Compute_collide}, 4'b0000);
    @(negedge clk_1);
    edg = 2'b00; collide = 1'b0;
  endtask

  // Serve phase: two frame ticks, Activate_cntr held until a single Initial_ball pulse.
  task automatic do_serve();
    int ib, ib_at, bad;
    ib = 0; ib_at = -1; bad = 0;
    for (int c = 0; c < 28; c++) begin
      clk_24 = ((c >= 4 && c < 8) || (c >= 12 && c < 16));
      @(negedge clk_1);
      if (Initial_ball) begin
        ib++; ib_at = c;
        if (Value_select) bad++;
      end else if (ib == 0 && !Activate_cntr) bad++;
      else if (ib > 0 && (Activate_cntr || Value_select)) bad++;
    end
    clk_24 = 1'b0;
    chk("serve_activate_vsel", bad, 0);
    chk("init_pulses", ib, 1);
    chk("init_cycle", ib_at, 15);
  endtask

  task automatic start_game();
    start = 1'b1;
    @(negedge clk_1);
    start = 1'b0;
    m_l = 0; m_r = 0; m_rally = 0; m_over = 1'b0; m_serve = 1'b0;
    chk("start_serve", {Activate_cntr, game_over, score_l, score_r, rally}, {1'b1, 1'b0, 16'h0});
  endtask

  initial begin
    int bad;
    logic [1:0] e;
    logic c;
    int r;
    rst_n = 1'b1; clk_24 = 1'b0; start = 1'b0; collide = 1'b0; edg = 2'b00; flag = 1'b0;
    vecs[0] = '{2'b00, 1'b1, 0, 0, 0, 1, 1'b0, 1'b0};
    vecs[1] = '{2'b11, 1'b1, 1, 0, 0, 2, 1'b0, 1'b0};
    vecs[2] = '{2'b11, 1'b0, 4, 0, 0, 2, 1'b0, 1'b0};
    vecs[3] = '{2'b00, 1'b0, 2, 0, 0, 2, 1'b0, 1'b0};
    vecs[4] = '{2'b00, 1'b1, 3, 0, 0, 3, 1'b0, 1'b0};
    vecs[5] = '{2'b10, 1'b1, 0, 1, 0, 0, 1'b1, 1'b0};
    vecs[6] = '{2'b00, 1'b1, 5, 1, 0, 1, 1'b0, 1'b0};
    vecs[7] = '{2'b01, 1'b0, 1, 1, 1, 0, 1'b1, 1'b0};
    vecs[8] = '{2'b00, 1'b1, 0, 1, 1, 1, 1'b0, 1'b0};
    vecs[9] = '{2'b01, 1'b1, 2, 1, 2, 1, 1'b0, 1'b1};

    repeat (2) @(negedge clk_1);
    chk("reset_outputs", outs_s, 22'h0);
    rst_n = 1'b0;
    @(negedge clk_1);
    chk("idle_outputs", outs_s, 22'h0);

    start_game();
    do_serve();

    for (int i = 0; i < 10; i++) begin
      do_step(vecs[i].edg, vecs[i].col, vecs[i].d, 1'b0);
      chk($sformatf("vec%0d score_l", i), score_l, vecs[i].sl);
      chk($sformatf("vec%0d score_r", i), score_r, vecs[i].sr);
      chk($sformatf("vec%0d rally", i), rally, vecs[i].rl);
      chk($sformatf("vec%0d serve", i), Activate_cntr, vecs[i].serve);
      chk($sformatf("vec%0d game_over", i), game_over, vecs[i].over);
      if (vecs[i].serve) do_serve();
    end

    bad = 0;
    for (int k = 0; k < 16; k++) begin
      clk_24 = ((k % 8) >= 4);
      @(negedge clk_1);
      if (!game_over || Activate_cntr || Compute_alter || score_r != 4'd2 || score_l != 4'd1) bad++;
    end
    clk_24 = 1'b0;
    chk("over_hold", bad, 0);
    start_game();
    do_serve();

    // A tick landing on the last COLLIDE cycle must not start another step.
    do_step(2'b00, 1'b0, 4, 1'b1);
    model_check(2'b00, 1'b0);
    check_state("late_tick");
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_1);
      if (Compute_alter || Compute_collide) bad++;
    end
    chk("late_tick_dropped", bad, 0);

    for (int k = 0; k < 258; k++) begin
      do_step(2'b00, 1'b1, 0, 1'b0);
      model_check(2'b00, 1'b1);
    end
    check_state("rally_saturate");

    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 15);
      e = (r < 2) ? 2'b01 : (r < 4) ? 2'b10 : (r < 10) ? 2'b00 : 2'b11;
      c = 1'($urandom_range(0, 1));
      do_step(e, c, $urandom_range(0, 5), 1'b0);
      model_check(e, c);
      check_state($sformatf("rand%0d", k));
      if (m_over) begin
        start_game();
        do_serve();
      end else if (m_serve) begin
        do_serve();
      end
    end

    clk_24 = 1'b0;
    repeat (3) @(negedge clk_1);
    clk_24 = 1'b1;
    bad = 1;
    for (int i = 0; i < 10 && bad == 1; i++) begin
      @(negedge clk_1);
      if (Compute_alter) bad = 0;
    end
    chk("rst_collide_reach_alter", bad, 0);
    clk_24 = 1'b0;
    @(negedge clk_1);
    chk("rst_collide_in_collide", Compute_collide, 1'b1);
    rst_n = 1'b1;
    @(negedge clk_1);
    chk("rst_collide_outputs", outs_s, 22'h0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk_1);
    chk("rst_collide_idle", outs_s, 22'h0);

    start_game();
    clk_24 = 1'b1;
    repeat (4) @(negedge clk_1);
    clk_24 = 1'b0;
    repeat (2) @(negedge clk_1);
    rst_n = 1'b1;
    @(negedge clk_1);
    chk("rst_serve_outputs", outs_s, 22'h0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk_1);
    chk("rst_serve_idle", outs_s, 22'h0);
    start_game();
    do_serve();

    chk("control_overlap", overlap_cnt, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
